lsu_mem_initiator: RTL and testbench

- Load/store unit that sits between the execute stage and Data_memory, and acts as the initiator for Data_memory.
- Accepts one load or store request at a time over a valid/ready handshake.
- Checks alignment and range, then drives Data_memory's memwrite/addr/store_type/load_type/wdata.
- Extracts and sign/zero-extends load data from rdata_word, and returns a one-cycle response with data or a fault.

---
 rtl/lsu_mem_initiator.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store unit driving Data_memory as its initiator
//
// Accepts one load/store at a time (valid/ready), checks size, alignment and
// range, performs the Data_memory access and returns a one-cycle response.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; ready only while IDLE
//   req_write            1 = store, 0 = load
//   req_size             00 word, 01 half, 10 byte, 11 illegal
//   req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle response pulse (no backpressure)
//   resp_rdata           extended load data; 0 for stores and faults
//   resp_fault           illegal size, misaligned or out of range
//   mem_*                Data_memory memwrite/addr/store_type/load_type/wdata
//   mem_rdata_word       combinational read of the aligned word at mem_addr
//
// Optional feature: define LSU_MISALIGN_SPLIT_EN to serve misaligned loads
// that cross a word boundary with two reads (ACCESS then ACCESS2).
module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_memwrite,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_store_type,
    output logic [1:0]            mem_load_type,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata_word
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] ACCESS2 = 2'd3;
`endif
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

    logic [1:0]            state;
    logic                  r_write, r_unsigned;
    logic [1:0]            r_off;
    logic [1:0]            off;
    logic [ADDR_WIDTH:0]   last_byte;
    logic                  misaligned, fault;
    logic [31:0]           load_word, load_ext;

    assign off        = req_addr[1:0];
    // One extra bit so addresses near the top of the space cannot wrap past the check
    assign last_byte  = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_size == 2'b00 ? 3 : req_size == 2'b01 ? 1 : 0);
    assign misaligned = req_size == 2'b00 ? off != 2'b00 : req_size == 2'b01 ? off[0] : 1'b0;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        need_split, r_split;
    logic [31:0] first_word;
    // Misaligned loads are served; only stores still fault on alignment
    assign fault      = req_size == 2'b11 || (misaligned && req_write) || last_byte >= LIMIT;
    // Half at offset 1 stays inside one word, so it needs no second read
    assign need_split = !req_write && (req_size == 2'b00 ? off != 2'b00 : req_size == 2'b01 && off == 2'b11);
    assign load_word  = state == ACCESS2 ? 32'({mem_rdata_word, first_word} >> {r_off, 3'b000})
                                         : mem_rdata_word >> {r_off, 3'b000};
`else
    assign fault      = req_size == 2'b11 || misaligned || last_byte >= LIMIT;
    assign load_word  = mem_rdata_word >> {r_off, 3'b000};
`endif

    // mem_store_type doubles as the captured access size
    assign load_ext = mem_store_type == 2'b10 ? {{24{!r_unsigned && load_word[7]}}, load_word[7:0]}
                    : mem_store_type == 2'b01 ? {{16{!r_unsigned && load_word[15]}}, load_word[15:0]}
                    : load_word;

    assign req_ready     = state == IDLE;
    assign resp_valid    = state == RESP;
    assign mem_memwrite  = state == ACCESS && r_write;
    assign mem_load_type = 2'b00;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            r_write        <= 1'b0;
            r_unsigned     <= 1'b0;
            r_off          <= 2'b00;
            mem_addr       <= '0;
            mem_store_type <= 2'b00;
            mem_wdata      <= '0;
            resp_rdata     <= '0;
            resp_fault     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split        <= 1'b0;
            first_word     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    if (fault) begin
                        state      <= RESP;
                        resp_fault <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state          <= ACCESS;
                        r_write        <= req_write;
                        r_unsigned     <= req_unsigned;
                        r_off          <= off;
                        mem_store_type <= req_size;
                        mem_wdata      <= req_wdata;
                        mem_addr       <= req_write ? req_addr : req_addr & ~ADDR_WIDTH'(3);
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_split        <= need_split;
`endif
                    end
                end
                ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    first_word <= mem_rdata_word;
                    if (r_split) mem_addr <= mem_addr + ADDR_WIDTH'(4);
                    state      <= r_split ? ACCESS2 : RESP;
`else
                    state      <= RESP;
`endif
                    resp_rdata <= r_write ? '0 : load_ext;
                    resp_fault <= 1'b0;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ACCESS2: begin
                    state      <= RESP;
                    resp_rdata <= load_ext;
                end
`endif
                default: begin
                    state      <= IDLE;
                    resp_rdata <= '0;
                    resp_fault <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed self-checking bench with a Data_memory model
module tb_lsu_mem_initiator;
    localparam int MEM_BYTES = 1024;

    logic        clk, resetn, req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, mem_memwrite;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata_word;
    logic [1:0]  mem_store_type, mem_load_type;

    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [31:0] word_addr;
    int          wr_count = 0;

    int          tests = 0, fails = 0;
    logic        x_ready, x_fault;
    logic [1:0]  x_st;
    logic [31:0] x_wa, x_wd, x_la, x_rdata;
    int          x_wr, x_resp_n, x_resp_cyc;

    lsu_mem_initiator #(.ADDR_WIDTH(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
        .mem_store_type(mem_store_type), .mem_load_type(mem_load_type),
        .mem_wdata(mem_wdata), .mem_rdata_word(mem_rdata_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_memory model: lane placement on store, combinational aligned word read
    assign word_addr = mem_addr & ~32'd3;
    always_comb mem_rdata_word = word_addr <= 32'(MEM_BYTES - 4)
        ? {mem[word_addr + 3], mem[word_addr + 2], mem[word_addr + 1], mem[word_addr]} : 32'h0;

    always @(posedge clk) begin
        if (mem_memwrite && mem_addr < 32'(MEM_BYTES)) begin
            wr_count <= wr_count + 1;
            if (mem_store_type == 2'b00)
                for (int i = 0; i < 4; i++) mem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            else if (mem_store_type == 2'b01)
                for (int i = 0; i < 2; i++) mem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            else
                mem[mem_addr] <= mem_wdata[7:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // One request from IDLE; observes 5 cycles after the accept edge
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        x_ready = req_ready; x_wr = 0; x_resp_n = 0; x_resp_cyc = 0;
        x_rdata = 32'hx; x_fault = 1'bx; x_st = 2'bx; x_wa = 32'hx; x_wd = 32'hx; x_la = 32'hx;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 1) x_la = mem_addr;
            if (mem_memwrite) begin x_wr++; x_st = mem_store_type; x_wa = mem_addr; x_wd = mem_wdata; end
            if (resp_valid) begin x_resp_n++; x_resp_cyc = k; x_rdata = resp_rdata; x_fault = resp_fault; end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #1 resetn = 1'b0;
        #2;
        tests++; if ({req_ready, resp_valid, mem_memwrite} !== 3'b100) begin fails++; $display("FAIL reset_ctrl got %b exp 100", {req_ready, resp_valid, mem_memwrite}); end
        tests++; if ({mem_addr, mem_wdata, resp_rdata} !== 96'h0) begin fails++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_addr, mem_wdata, resp_rdata); end
        tests++; if ({resp_fault, mem_store_type, mem_load_type} !== 5'b0) begin fails++; $display("FAIL reset_types got %b exp 0", {resp_fault, mem_store_type, mem_load_type}); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tests++; if ({req_ready, resp_valid, mem_memwrite} !== 3'b100) begin fails++; $display("FAIL post_reset got %b exp 100", {req_ready, resp_valid, mem_memwrite}); end
    endtask

    task automatic test_reset_mid_access;
        int base, seen;
        base = wr_count; seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h100; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        tests++; if (mem_memwrite !== 1'b1) begin fails++; $display("FAIL mid_rst_access memwrite got %b exp 1", mem_memwrite); end
        #2 resetn = 1'b0;
        #1;
        tests++; if (mem_memwrite !== 1'b0) begin fails++; $display("FAIL mid_rst_drop memwrite got %b exp 0", mem_memwrite); end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL mid_rst_resp count got %0d exp 0", seen); end
        tests++; if (wr_count != base) begin fails++; $display("FAIL mid_rst_write count got %0d exp %0d", wr_count, base); end
    endtask

    task automatic test_word;
        xact(1'b1, 2'b00, 1'b0, 32'h4, 32'hDEADBEEF);
        tests++; if (x_ready !== 1'b1) begin fails++; $display("FAIL sw_ready got %b exp 1", x_ready); end
        tests++; if (x_wr != 1 || x_st !== 2'b00) begin fails++; $display("FAIL sw_memwrite got %0d cycles type %b exp 1 cycle type 00", x_wr, x_st); end
        tests++; if (x_wa !== 32'h4 || x_wd !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_bus got %h/%h exp 4/deadbeef", x_wa, x_wd); end
        tests++; if (x_resp_n != 1 || x_resp_cyc != 2 || x_fault !== 1'b0 || x_rdata !== 32'h0) begin fails++; $display("FAIL sw_resp got n=%0d cyc=%0d f=%b d=%h exp 1/2/0/0", x_resp_n, x_resp_cyc, x_fault, x_rdata); end
        xact(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        tests++; if (x_resp_n != 1 || x_resp_cyc != 2 || x_fault !== 1'b0) begin fails++; $display("FAIL lw_timing got n=%0d cyc=%0d f=%b exp 1/2/0", x_resp_n, x_resp_cyc, x_fault); end
        tests++; if (x_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h exp deadbeef", x_rdata); end
        tests++; if (x_wr != 0 || x_la !== 32'h4) begin fails++; $display("FAIL lw_bus got wr=%0d addr=%h exp 0/4", x_wr, x_la); end
    endtask

    task automatic test_half;
        xact(1'b1, 2'b01, 1'b0, 32'h6, 32'h1234ABCD);
        tests++; if (x_wr != 1 || x_st !== 2'b01 || x_wa !== 32'h6 || x_wd !== 32'h1234ABCD) begin fails++; $display("FAIL sh_bus got %0d/%b/%h/%h exp 1/01/6/1234abcd", x_wr, x_st, x_wa, x_wd); end
        xact(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        tests++; if (x_rdata !== 32'hFFFFABCD || x_la !== 32'h4) begin fails++; $display("FAIL lh_signed got %h addr %h exp ffffabcd addr 4", x_rdata, x_la); end
        xact(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        tests++; if (x_rdata !== 32'h0000ABCD || x_resp_cyc != 2) begin fails++; $display("FAIL lhu got %h cyc %0d exp 0000abcd cyc 2", x_rdata, x_resp_cyc); end
    endtask

    task automatic test_byte;
        xact(1'b1, 2'b10, 1'b0, 32'h7, 32'h000000EF);
        tests++; if (x_wr != 1 || x_st !== 2'b10 || x_wa !== 32'h7) begin fails++; $display("FAIL sb_bus got %0d/%b/%h exp 1/10/7", x_wr, x_st, x_wa); end
        xact(1'b0, 2'b10, 1'b0, 32'h7, 32'h0);
        tests++; if (x_rdata !== 32'hFFFFFFEF || x_la !== 32'h4) begin fails++; $display("FAIL lb_signed got %h addr %h exp ffffffef addr 4", x_rdata, x_la); end
        xact(1'b0, 2'b10, 1'b1, 32'h5, 32'h0);
        tests++; if (x_rdata !== 32'h000000BE) begin fails++; $display("FAIL lbu_lane1 got %h exp 000000be", x_rdata); end
        xact(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        tests++; if (x_rdata !== 32'hEFCDBEEF) begin fails++; $display("FAIL lw_merged got %h exp efcdbeef", x_rdata); end
    endtask

    task automatic test_faults;
        logic        fw [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  fs [6] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10};
        logic [31:0] fa [6] = '{32'h5, 32'h3, 32'h0, 32'(MEM_BYTES - 2), 32'(MEM_BYTES), 32'(MEM_BYTES)};
        for (int i = 0; i < 6; i++) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (i == 0) continue;
`endif
            xact(fw[i], fs[i], 1'b0, fa[i], 32'hFFFFFFFF);
            tests++; if (x_fault !== 1'b1 || x_rdata !== 32'h0 || x_wr != 0) begin fails++; $display("FAIL fault_%0d got f=%b d=%h wr=%0d exp 1/0/0", i, x_fault, x_rdata, x_wr); end
            tests++; if (x_resp_n != 1 || x_resp_cyc < 1 || x_resp_cyc > 2) begin fails++; $display("FAIL fault_%0d_timing got n=%0d cyc=%0d exp one pulse by cycle 2", i, x_resp_n, x_resp_cyc); end
        end
        xact(1'b1, 2'b10, 1'b0, 32'(MEM_BYTES - 1), 32'h00000080);
        tests++; if (x_wr != 1 || x_fault !== 1'b0) begin fails++; $display("FAIL sb_top got wr=%0d f=%b exp 1/0", x_wr, x_fault); end
        xact(1'b0, 2'b10, 1'b0, 32'(MEM_BYTES - 1), 32'h0);
        tests++; if (x_rdata !== 32'hFFFFFF80 || x_fault !== 1'b0) begin fails++; $display("FAIL lb_top got %h f=%b exp ffffff80/0", x_rdata, x_fault); end
`ifdef LSU_MISALIGN_SPLIT_EN
        xact(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000005A);
        xact(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        tests++; if (x_rdata !== 32'h5AEFCDBE || x_fault !== 1'b0 || x_resp_cyc != 3) begin fails++; $display("FAIL split_lw got %h f=%b cyc=%0d exp 5aefcdbe/0/3", x_rdata, x_fault, x_resp_cyc); end
`endif
    endtask

    task automatic test_back_to_back;
        int acc, rsp, bad, extra;
        acc = 0; rsp = 0; bad = 0; extra = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h4;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (req_ready) acc++;
            if (req_ready !== (k % 3 == 0)) bad++;
            if (resp_valid) begin rsp++; if (resp_rdata !== 32'hEFCDBEEF) bad++; end
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        tests++; if (acc != 4 || rsp != 4) begin fails++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 4/4", acc, rsp); end
        tests++; if (bad != 0 || extra != 0) begin fails++; $display("FAIL b2b_pattern got bad=%0d extra=%0d exp 0/0", bad, extra); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_access;
        test_word;
        test_half;
        test_byte;
        test_faults;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
